// File: rtl/seg7_scan_driver_if.sv
// Purpose : write port and pin bundle of the seven-segment scan driver.
// Latency : n/a (wires only).
// Backpr. : none; the write strobe is fire-and-forget, seg_busy is status only.
// Ports   : seg_wen/seg_sel/seg_wdata  MMIO write strobe, register select, data
//           seg_busy                   conversion in progress
//           seg_an/seg_out             active-low anodes and {dp,g..a} segments
interface seg7_scan_driver_if;
  logic        seg_wen;
  logic [1:0]  seg_sel;
  logic [31:0] seg_wdata;
  logic        seg_busy;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  // master: the IO mux / CPU side that issues writes and watches the pins
  modport master (
    output seg_wen, seg_sel, seg_wdata,
    input  seg_busy, seg_an, seg_out
  );

  // slave: the scan driver itself
  modport slave (
    input  seg_wen, seg_sel, seg_wdata,
    output seg_busy, seg_an, seg_out
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Purpose : latch MMIO value/mode/enable writes, render value as hex or decimal, scan 8 digits.
// Latency : write edge to display buffer: 2 edges (hex), 34 edges (decimal); pins registered.
// Backpr. : none; any value/mode write restarts the renderer, aborting work in flight.
// Ports   : clk, rst (async, active-high); bus (slave modport of seg7_scan_driver_if):
//           seg_wen/seg_sel/seg_wdata in, seg_busy/seg_an/seg_out out.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 25000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  // Digit codes: 0..15 are hex glyphs; two extra codes need a fifth bit.
  localparam logic [4:0] CODE_DASH  = 5'd16;
  localparam logic [4:0] CODE_BLANK = 5'd17;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t      state;
  logic [31:0] value;
  logic [2:0]  mode;       // [0] decimal, [1] leading-zero blank, [2] signed
  logic [7:0]  enable;
  logic        start_pend; // a value/mode write landed last edge
  logic [31:0] conv_val;   // snapshot used by the running conversion
  logic [2:0]  conv_mode;
  logic [31:0] bin_sr;
  logic [39:0] bcd;
  logic [39:0] bcd_adj;
  logic [4:0]  shift_cnt;
  logic        busy;
  logic [4:0]  digbuf [8];

  logic [CW-1:0] scan_cnt;
  logic [2:0]    scan_idx;

  logic          wr_start;
  logic [31:0]   magnitude;
  logic [3:0]    src [8];
  logic [2:0]    msd;
  logic          neg_c;
  logic          ovf;
  logic [4:0]    code_c [8];

  assign wr_start     = bus.seg_wen && !bus.seg_sel[1];
  assign magnitude    = (mode[2] && value[31]) ? 32'(-value) : value;
  assign bus.seg_busy = busy;

  // Double-dabble correction applied before every shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Codes written into the display buffer during COMMIT.
  always_comb begin
    neg_c = conv_mode[0] & conv_mode[2] & conv_val[31];
    // Signed mode reserves one digit for the sign, so only 7 magnitude digits fit.
    ovf   = conv_mode[0] & (conv_mode[2] ? (bcd[39:28] != 12'd0) : (bcd[39:32] != 8'd0));
    msd   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      src[i] = conv_mode[0] ? bcd[4*i +: 4] : conv_val[4*i +: 4];
      if (src[i] != 4'd0) msd = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      code_c[i] = {1'b0, src[i]};
      if (conv_mode[1] && i > int'(msd)) code_c[i] = CODE_BLANK;
      if (neg_c && (conv_mode[1] ? (i == int'(msd) + 1) : (i == 7))) code_c[i] = CODE_DASH;
      if (ovf) code_c[i] = CODE_DASH;
    end
  end

  // Register file plus render FSM. A pending start beats everything, so a
  // write during CONV or COMMIT discards the old result without committing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      value      <= '0;
      mode       <= '0;
      enable     <= 8'hFF;
      start_pend <= 1'b0;
      conv_val   <= '0;
      conv_mode  <= '0;
      bin_sr     <= '0;
      bcd        <= '0;
      shift_cnt  <= '0;
      busy       <= 1'b0;
      for (int i = 0; i < 8; i++) digbuf[i] <= '0;
    end else begin
      start_pend <= wr_start;
      if (bus.seg_wen) begin
        case (bus.seg_sel)
          2'd0:    value  <= bus.seg_wdata;
          2'd1:    mode   <= bus.seg_wdata[2:0];
          2'd2:    enable <= bus.seg_wdata[7:0];
          default: ;
        endcase
      end

      if (start_pend) begin
        conv_val  <= value;
        conv_mode <= mode;
        busy      <= 1'b1;
        if (mode[0]) begin
          state     <= CONV;
          bin_sr    <= magnitude;
          bcd       <= '0;
          shift_cnt <= '0;
        end else begin
          state <= COMMIT;
        end
      end else begin
        case (state)
          CONV: begin
            {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
            shift_cnt     <= shift_cnt + 5'd1;
            if (shift_cnt == 5'd31) state <= COMMIT;
          end
          COMMIT: begin
            for (int i = 0; i < 8; i++) digbuf[i] <= code_c[i];
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [7:0] glyph(input logic [4:0] c);
    case (c)
      5'd0:  glyph = 8'hC0;
      5'd1:  glyph = 8'hF9;
      5'd2:  glyph = 8'hA4;
      5'd3:  glyph = 8'hB0;
      5'd4:  glyph = 8'h99;
      5'd5:  glyph = 8'h92;
      5'd6:  glyph = 8'h82;
      5'd7:  glyph = 8'hF8;
      5'd8:  glyph = 8'h80;
      5'd9:  glyph = 8'h90;
      5'd10: glyph = 8'h88;
      5'd11: glyph = 8'h83;
      5'd12: glyph = 8'hC6;
      5'd13: glyph = 8'hA1;
      5'd14: glyph = 8'h86;
      5'd15: glyph = 8'h8E;
      5'd16: glyph = 8'hBF;
      default: glyph = 8'hFF;
    endcase
  endfunction

  // Digit scan: the pins reflect the slot selected before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      scan_idx    <= '0;
      bus.seg_an  <= 8'hFF;
      bus.seg_out <= 8'hFF;
    end else begin
      if (scan_cnt == CNT_MAX) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      bus.seg_an  <= ~({7'd0, enable[scan_idx]} << scan_idx);
      bus.seg_out <= glyph(digbuf[scan_idx]);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus();
  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [7:0] hexg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Rendered display as 8 glyph bytes, digit i in bits [8i+7:8i].
  function automatic logic [63:0] fmt(input logic [31:0] v, input logic [2:0] m);
    logic [63:0] r;
    longint mag, lim, p;
    int d [8];
    int top;
    bit neg;
    r = '0; top = 0; neg = 0;
    if (!m[0]) begin
      for (int i = 0; i < 8; i++) d[i] = int'((v >> (4*i)) & 32'hF);
    end else begin
      neg = m[2] && v[31];
      mag = longint'({32'd0, v});
      if (neg) mag = longint'(64'h1_0000_0000) - mag;
      lim = m[2] ? 64'd9999999 : 64'd99999999;
      if (mag > lim) return {8{8'hBF}};
      p = 1;
      for (int i = 0; i < 8; i++) begin
        d[i] = int'((mag / p) % 10);
        p = p * 10;
      end
    end
    for (int i = 0; i < 8; i++) if (d[i] != 0) top = i;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = hexg[d[i]];
      if (m[1] && i > top) r[8*i +: 8] = 8'hFF;
    end
    if (neg) begin
      if (m[1]) r[8*(top+1) +: 8] = 8'hBF;
      else      r[63:56] = 8'hBF;
    end
    return r;
  endfunction

  // Reference model: registers as seen by software, a single pending render
  // that lands a fixed number of edges after its write unless another
  // value/mode write supersedes it, and a scan slot derived from edge count.
  int          k = 0;
  int          m_idx;
  logic [31:0] m_val = '0;
  logic [2:0]  m_mode = '0;
  logic [7:0]  m_en = 8'hFF;
  logic [63:0] m_disp = {8{8'hC0}};
  bit          pend = 0;
  int          due = 0;
  logic [31:0] p_val;
  logic [2:0]  p_mode;
  int          busy_lo = 1, busy_hi = 0;
  logic [7:0]  e_an = 8'hFF, e_out = 8'hFF;
  logic        e_busy = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; m_val = '0; m_mode = '0; m_en = 8'hFF; m_disp = {8{8'hC0}};
      pend = 0; busy_lo = 1; busy_hi = 0;
      e_an = 8'hFF; e_out = 8'hFF; e_busy = 1'b0;
    end else begin
      k++;
      m_idx = ((k - 1) / SCAN_DIV) % 8;
      e_an  = m_en[m_idx] ? ~(8'd1 << m_idx) : 8'hFF;
      e_out = m_disp[8*m_idx +: 8];
      if (pend && k == due) begin
        m_disp = fmt(p_val, p_mode);
        pend = 0;
      end
      if (bus.seg_wen) begin
        case (bus.seg_sel)
          2'd0: m_val  = bus.seg_wdata;
          2'd1: m_mode = bus.seg_wdata[2:0];
          2'd2: m_en   = bus.seg_wdata[7:0];
          default: ;
        endcase
        if (!bus.seg_sel[1]) begin
          if (!pend) busy_lo = k + 1;
          pend = 1; p_val = m_val; p_mode = m_mode;
          due = k + (m_mode[0] ? 34 : 2);
          busy_hi = due - 1;
        end
      end
      e_busy = (k >= busy_lo && k <= busy_hi);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("busy", {63'd0, bus.seg_busy}, {63'd0, e_busy});
    chk("an",   {56'd0, bus.seg_an},   {56'd0, e_an});
    chk("seg",  {56'd0, bus.seg_out},  {56'd0, e_out});
  end

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk);
    bus.seg_wen = 1'b1; bus.seg_sel = sel; bus.seg_wdata = d;
    @(negedge clk);
    bus.seg_wen = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.seg_busy) n++;
    end
  endtask

  task automatic capture(output logic [63:0] got);
    got = '0;
    repeat (36) begin
      @(posedge clk); #1;
      for (int p = 0; p < 8; p++)
        if (bus.seg_an == ~(8'd1 << p)) got[8*p +: 8] = bus.seg_out;
    end
  endtask

  logic [31:0] bnd [10] = '{32'd99999999, 32'd100000000, 32'd9999999, 32'd10000000,
                            32'hFF676981, 32'hFF676980, 32'd0, 32'h80000000,
                            32'hFFFFFFFF, 32'd7};

  initial begin
    int n, ff_cnt, sel;
    logic [63:0] g;
    logic [31:0] d;
    int chk_at [5] = '{1, 4, 5, 29, 32};
    logic [7:0] an_at [5] = '{8'hFE, 8'hFE, 8'hFD, 8'h7F, 8'h7F};

    bus.seg_wen = 1'b0; bus.seg_sel = 2'd0; bus.seg_wdata = '0;

    // Model pins against hand-derived renderings.
    chk("fmt_hex",  fmt(32'h1234ABCD, 3'd0), 64'hF9A4B099_8883C6A1);
    chk("fmt_305",  fmt(32'd305, 3'd3),      64'hFFFFFFFF_FFB0C092);
    chk("fmt_m42",  fmt(32'hFFFFFFD6, 3'd7), 64'hFFFFFFFF_FFBF99A4);
    chk("fmt_m42n", fmt(32'hFFFFFFD6, 3'd5), 64'hBFC0C0C0_C0C099A4);
    chk("fmt_ovf",  fmt(32'd100000000, 3'd1), {8{8'hBF}});

    repeat (3) @(negedge clk);
    chk("rst_an", {56'd0, bus.seg_an}, 64'hFF);
    rst = 1'b0;

    // Scan from reset: 4 cycles per slot, right to left.
    for (int j = 1; j <= 32; j++) begin
      @(posedge clk); #1;
      for (int t = 0; t < 5; t++)
        if (chk_at[t] == j) chk("scan_an", {56'd0, bus.seg_an}, {56'd0, an_at[t]});
    end
    capture(g); chk("disp_rst", g, {8{8'hC0}});

    wr(2'd0, 32'h1234ABCD); busy_len(n); chk("busy_hex", n, 1);
    capture(g); chk("disp_hex", g, 64'hF9A4B099_8883C6A1);

    wr(2'd1, 32'd3); busy_len(n);
    capture(g); chk("disp_ovf_u", g, {8{8'hBF}});
    wr(2'd0, 32'd305); busy_len(n); chk("busy_dec", n, 33);
    capture(g); chk("disp_305", g, 64'hFFFFFFFF_FFB0C092);

    wr(2'd1, 32'd7); wr(2'd0, 32'hFFFFFFD6); busy_len(n);
    capture(g); chk("disp_m42", g, 64'hFFFFFFFF_FFBF99A4);

    wr(2'd1, 32'd1); wr(2'd0, 32'd100000000); busy_len(n);
    capture(g); chk("disp_1e8", g, {8{8'hBF}});
    wr(2'd0, 32'd5); repeat (10) @(negedge clk);
    wr(2'd0, 32'd77); busy_len(n); chk("busy_abort", n, 33);
    capture(g); chk("disp_77", g, 64'hC0C0C0C0_C0C0F8F8);

    wr(2'd2, 32'h0F); repeat (2) @(negedge clk);
    ff_cnt = 0;
    repeat (32) begin
      @(posedge clk); #1;
      if (bus.seg_an == 8'hFF) ff_cnt++;
    end
    chk("en_off_slots", ff_cnt, 16);
    wr(2'd2, 32'hFF);

    wr(2'd1, 32'd1); repeat (10) @(negedge clk);
    rst = 1'b1; #1;
    chk("rst_busy", {63'd0, bus.seg_busy}, 64'd0);
    chk("rst_an2",  {56'd0, bus.seg_an},   64'hFF);
    chk("rst_seg2", {56'd0, bus.seg_out},  64'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    capture(g); chk("disp_after_rst", g, {8{8'hC0}});

    // Randomized traffic, checked each cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 1999) == 0) begin
        rst = 1'b1; bus.seg_wen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end else if ($urandom_range(0, 99) < ((c < 2000) ? 3 : 9)) begin
        sel = $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          0:       d = $urandom_range(0, 999);
          1:       d = bnd[$urandom_range(0, 9)];
          2:       d = 32'(-$urandom_range(0, 20000000));
          default: d = $urandom;
        endcase
        if (sel == 1) d = $urandom_range(0, 7);
        bus.seg_wen = 1'b1; bus.seg_sel = 2'(sel); bus.seg_wdata = d;
      end else begin
        bus.seg_wen = 1'b0;
      end
    end
    @(negedge clk); bus.seg_wen = 1'b0;
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
